// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired-zero x0, optional write bypass,
// and a per-register busy scoreboard for decode RAW-hazard stalls.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   write_enable    writeback valid
//   write_addr      writeback destination
//   write_data      writeback value
//   issue_valid     decode issued an instruction with a destination
//   issue_addr      destination of that instruction (marks it busy)
//   read_addr       NUM_READ packed read addresses
//   read_data       NUM_READ packed combinational read values
//   read_busy       per-port "source still pending" flag
//   busy_vec        registered scoreboard state, bit 0 always 0

module regfile_scoreboard #(
   parameter int  WIDTH    = 32,
   parameter int  SIZE     = 32,
   parameter int  NUM_READ = 2,
   parameter int  BYPASS   = 1,
   localparam int ADDR_W   = $clog2(SIZE)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_enable,
   input  logic [ADDR_W-1:0]          write_addr,
   input  logic [WIDTH-1:0]           write_data,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_addr,
   input  logic [NUM_READ*ADDR_W-1:0] read_addr,
   output logic [NUM_READ*WIDTH-1:0]  read_data,
   output logic [NUM_READ-1:0]        read_busy,
   output logic [SIZE-1:0]            busy_vec
);

   // x0 has no storage; regs_q only covers 1..SIZE-1
   logic [WIDTH-1:0]  regs_q [1:SIZE-1];
   logic [WIDTH-1:0]  rf     [SIZE];
   logic [SIZE-1:0]   busy_q;
   logic [SIZE-1:0]   busy_d;
   logic [ADDR_W-1:0] ra;
   logic              fwd;

   always_ff @(posedge clk) begin
      for (int r = 1; r < SIZE; r++) begin
         if (reset) begin
            regs_q[r] <= '0;
         end else if (write_enable && write_addr == ADDR_W'(r)) begin
            regs_q[r] <= write_data;
         end
      end
   end

   // Issue beats writeback on the same register: the new producer
   // still owns the destination after the older result lands.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < SIZE; r++) begin
         if (issue_valid && issue_addr == ADDR_W'(r)) begin
            busy_d[r] = 1'b1;
         end else if (write_enable && write_addr == ADDR_W'(r)) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Flat view with a constant-zero x0 so reads index without range gaps
   always_comb begin
      rf[0] = '0;
      for (int r = 1; r < SIZE; r++) begin
         rf[r] = regs_q[r];
      end
   end

   always_comb begin
      read_data = '0;
      read_busy = '0;
      ra        = '0;
      fwd       = 1'b0;
      for (int p = 0; p < NUM_READ; p++) begin
         ra  = read_addr[p*ADDR_W +: ADDR_W];
         fwd = (BYPASS != 0) && write_enable && (write_addr == ra);
         if (ra == '0) begin
            read_data[p*WIDTH +: WIDTH] = '0;
            read_busy[p]                = 1'b0;
         end else if (fwd) begin
            // forwarded value satisfies the hazard this cycle
            read_data[p*WIDTH +: WIDTH] = write_data;
            read_busy[p]                = 1'b0;
         end else begin
            read_data[p*WIDTH +: WIDTH] = rf[ra];
            read_busy[p]                = busy_q[ra];
         end
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RISC-V core, replacing the fixed 2-read/1-write file.
- Provides NUM_READ combinational read ports, one synchronous write port, and a hardwired-zero x0.
- Adds optional write-to-read bypass and a per-register busy scoreboard. Decode uses the scoreboard for RAW hazard stalls; writeback clears it.

Parameters:
- WIDTH, 32, data width of each register.
- SIZE, 32, number of registers. Must be a power of 2 and at least 2.
- NUM_READ, 2, number of independent read ports, 1..4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads; when 0 reads return the stored value.
- ADDR_W (localparam), $clog2(SIZE), register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- write_enable  in  1  writeback valid.
- write_addr  in  ADDR_W  writeback destination.
- write_data  in  WIDTH  writeback value.
- issue_valid  in  1  decode issued an instruction that has a destination.
- issue_addr  in  ADDR_W  destination of the issued instruction.
- read_addr  in  NUM_READ*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- read_data  out  NUM_READ*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH].
- read_busy  out  NUM_READ  port i source is still pending (RAW hazard).
- busy_vec  out  SIZE  full scoreboard state; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On a posedge with reset=1:
  - all registers become 0;
  - all busy bits are cleared;
  - write and issue in that cycle are ignored.
- Reset values of outputs (visible after the reset edge): read_data=0 on every port, read_busy=0, busy_vec=0.
- Storage: registers 1..SIZE-1 are flops. Register 0 is not stored.
- Write: at posedge, if write_enable=1 and write_addr!=0, reg[write_addr] <= write_data. A write to x0 is discarded.
- Read: combinational, zero latency, per port i:
  - if read_addr_i==0, read_data_i = 0;
  - else if BYPASS=1 and write_enable=1 and write_addr==read_addr_i, read_data_i = write_data;
  - else read_data_i = reg[read_addr_i].
  - All ports are independent. Several ports may read the same address in one cycle.
- Scoreboard: one busy bit per register. At posedge, for each register r:
  - r==0: busy stays 0.
  - issue_valid=1 and issue_addr==r: busy[r] <= 1. This holds even if a writeback to r occurs in the same cycle; the new producer wins.
  - else write_enable=1 and write_addr==r: busy[r] <= 0.
  - else busy[r] holds.
- Write while not busy: a write to a register whose busy bit is 0 is legal. The data updates and busy stays 0.
- read_busy_i (combinational):
  - 0 if read_addr_i==0;
  - else 0 if BYPASS=1 and write_enable=1 and write_addr==read_addr_i, because the value is forwarded this cycle;
  - else busy[read_addr_i].
- busy_vec reflects registered state only; no bypass is applied.
- No internal FSM beyond the register and scoreboard state. There is no backpressure; the block accepts every write and issue each cycle.
- Unknown or X inputs are out of scope. Addresses are always in range because SIZE is a power of 2.

Test Plan:
- Reset then read: assert reset 1 cycle, then read x5 on all ports -> read_data=0, read_busy=0, busy_vec=0.
- Write/read: write x3=0xDEADBEEF, next cycle read port0=x3, port1=x0 -> port0=0xDEADBEEF, port1=0. Then write x0=0x1234 and read x0 -> 0.
- Bypass:
  - BYPASS=1: write x7=0xA5A5A5A5 and read x7 in the same cycle -> read_data=0xA5A5A5A5, read_busy=0.
  - BYPASS=0: same stimulus -> old value; new value on the next cycle.
- Scoreboard: issue x9, next cycle read x9 -> read_busy=1, busy_vec[9]=1. Write x9=0x55 -> with BYPASS=1 read_busy=0 that cycle; busy_vec[9]=0 after the edge.
- Simultaneous issue and write to x4 while busy[4]=1 -> busy[4] remains 1 after the edge and reg[4] is updated. Issue x0 -> busy_vec[0] stays 0.
- Reset mid-operation: set busy for x1..x8 and write nonzero data, assert reset together with write x2=0xFF -> all regs=0, busy_vec=0, and the x2 write is dropped.
